muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Multi-cycle 8-bit multiply/divide unit that sits between the register file read ports (RD1/RD2) and its write port (WA3/WD3/we3).
- Consumes two operands plus a destination register index, iterates one bit per cycle, then writes the result back to the register file through its own write-back port.
- Holds the PC via a stall output while active.
- The datapath muxes wb_we/wb_addr/wb_data onto the register file write port whenever wb_we=1.

Parameters:
WIDTH, 8, operand/result width in bits (must match register width)
AW, 4, register address width
CW, 4, iteration counter width; must satisfy 2^CW > WIDTH

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  launch operation; sampled only in IDLE
op  in  2  00 MUL (low half), 01 MULW (low half to rd, high half to rd+1), 10 DIV (quotient), 11 MOD (remainder)
a  in  WIDTH  operand A (multiplicand / dividend), from RD1
b  in  WIDTH  operand B (multiplier / divisor), from RD2
rd  in  AW  destination register index
busy  out  1  unit not in IDLE
stall  out  1  busy | (start & idle); freezes PC/fetch
wb_we  out  1  register file write enable
wb_addr  out  AW  register file write address
wb_data  out  WIDTH  register file write data
done  out  1  one-cycle pulse in last write-back cycle
div_zero  out  1  sticky: last DIV/MOD had b==0

Behaviour:
- Reset (async, active-high): state=IDLE. busy=0, stall=0, wb_we=0, wb_addr=0, wb_data=0, done=0, div_zero=0. Internal operand, accumulator and counter registers are cleared to 0.
- Reset asserted mid-operation aborts immediately. No write-back is issued for the aborted operation, either during reset or after it.
- States: IDLE -> CALC -> WB_LO -> (WB_HI) -> IDLE.
- IDLE, start=1:
  - Latch a, b, op, rd; counter=0; state goes to CALC.
  - div_zero is cleared on this edge, then set again at the end of CALC if op[1]=1 and b==0.
  - start=0: remain in IDLE.
- CALC: exactly WIDTH cycles, one bit per cycle, counter 0..WIDTH-1.
  - MUL/MULW: shift-add into a 2*WIDTH-bit accumulator, unsigned.
  - DIV/MOD: restoring division.
    - Partial remainder is WIDTH+1 bits.
    - Quotient bit is 1 when the trial subtraction is non-negative.
- After the last CALC cycle, state goes to WB_LO.
- Division by zero: quotient = all ones (8'hFF), remainder = a. No trap is raised.
- WB_LO: one cycle, wb_we=1, wb_addr=rd.
  - wb_data = product[WIDTH-1:0] for MUL/MULW, quotient for DIV, remainder for MOD.
  - If op=MULW, next state is WB_HI; otherwise done=1 and next state is IDLE.
- WB_HI (MULW only): one cycle, wb_addr = rd+1 modulo 2^AW (15 wraps to 0), wb_data = product[2*WIDTH-1:WIDTH], done=1. Next state is IDLE.
- Register 0 suppression: wb_we is forced to 0 whenever wb_addr==0; done still pulses. This covers rd=0, and rd=15 for MULW.
- wb_addr/wb_data outside write-back states: hold their last values.
- Latency, start sampled at edge 0:
  - WB_LO is active in cycle WIDTH+1 (cycle 9 for WIDTH=8).
  - WB_HI in cycle WIDTH+2.
  - busy drops the cycle after the final write-back cycle.
- start asserted while busy: ignored, with no queueing. Operand changes while busy are ignored because inputs are latched.
- start in the same cycle that the final write-back completes: ignored. A new start is accepted only when state=IDLE.
- stall is combinational from start and state, so the PC is held in the same cycle start is raised.

Optional Feature:
MULDIV_SIGNED_EN
- Defined: adds input port sgn (1 bit), latched with start.
  - When sgn=1, a and b are two's complement. The unit latches their magnitudes and runs the unsigned CALC.
  - One extra FIX state, between CALC and WB_LO, negates results: product if signs differ; quotient if signs differ; remainder takes the sign of a.
  - Signed latency is one cycle longer. DIV/MOD by zero gives quotient = 8'hFF and remainder = a, unchanged.
  - With sgn=0, timing and behaviour are identical to the undefined build.
- Undefined: no sgn port, no FIX state; all arithmetic is unsigned.

Test Plan:
- MUL a=8'd13, b=8'd11, rd=3: single write in cycle 9, wb_addr=3, wb_data=8'h8F; done pulses; busy=0 in cycle 10.
- MULW a=8'hFF, b=8'hFF, rd=15: WB_LO addr 15, data 8'h01, we=1; WB_HI addr 0, data 8'hFE, we=0 (suppressed); done pulses on WB_HI.
- DIV a=8'd200, b=8'd7 then MOD with same operands: DIV writes 8'd28, MOD writes 8'd4; div_zero=0 for both.
- DIV a=8'd50, b=0: writes 8'hFF and div_zero=1; then start MUL 2*3 -> div_zero clears on that start, writes 8'd6.
- Start MUL, pulse start with new operands in cycle 4, assert reset in cycle 6: second start ignored; after reset, all outputs 0, no wb_we, state IDLE.
- (MULDIV_SIGNED_EN) sgn=1, MULW a=8'hFA (-6), b=8'd7: WB_LO data 8'hD6, WB_HI data 8'hFF, WB_LO in cycle 10; DIV a=-7 (8'hF9), b=2 -> 8'hFD; MOD a=-7, b=2 -> 8'hFF.

Source files
------------

// File: rtl/muldiv_seq_if.sv
// Request/write-back bundle between the datapath and the muldiv_seq unit.
// Optional MULDIV_SIGNED_EN adds the sgn request bit.
interface muldiv_seq_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
);
  // Handshake: start is a request that is taken only when busy=0 (IDLE) and
  // has no ready/ack of its own. The operands a/b/op/rd (and sgn) are captured
  // on that edge. busy stays high until the last write-back cycle has been
  // issued. stall = busy | (start & idle), so fetch is held from the request
  // cycle onward. wb_we/wb_addr/wb_data form a one-cycle write per result, and
  // done marks the final one.
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [AW-1:0]    rd;
`ifdef MULDIV_SIGNED_EN
  logic             sgn;
`endif
  logic             busy;
  logic             stall;
  logic             wb_we;
  logic [AW-1:0]    wb_addr;
  logic [WIDTH-1:0] wb_data;
  logic             done;
  logic             div_zero;

`ifdef MULDIV_SIGNED_EN
  modport master (output start, op, a, b, rd, sgn,
                  input  busy, stall, wb_we, wb_addr, wb_data, done, div_zero);
  modport slave  (input  start, op, a, b, rd, sgn,
                  output busy, stall, wb_we, wb_addr, wb_data, done, div_zero);
`else
  modport master (output start, op, a, b, rd,
                  input  busy, stall, wb_we, wb_addr, wb_data, done, div_zero);
  modport slave  (input  start, op, a, b, rd,
                  output busy, stall, wb_we, wb_addr, wb_data, done, div_zero);
`endif
endinterface

// File: rtl/muldiv_seq.sv
// Bit-serial 8-bit multiply/divide unit that writes its results back into the register file.
// Optional MULDIV_SIGNED_EN adds two's-complement operands and a FIX state that applies the result signs.
module muldiv_seq #(
  parameter int WIDTH = 8,
  parameter int AW    = 4,
  parameter int CW    = 4
) (
  input  logic         clk,
  input  logic         reset,
  muldiv_seq_if.slave  bus,
  output logic [2:0]   state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CALC  = 3'd1,
`ifdef MULDIV_SIGNED_EN
    S_FIX   = 3'd2,
`endif
    S_WB_LO = 3'd3,
    S_WB_HI = 3'd4
  } state_t;

  localparam logic [1:0] OP_MULW = 2'b01;
  localparam logic [1:0] OP_MOD  = 2'b11;

  state_t             state, state_nx;
  logic [1:0]         op_q;
  logic [AW-1:0]      rd_q;
  logic [WIDTH-1:0]   opa, opb;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     rem;
  logic [CW-1:0]      cnt;
  logic               div_zero_q;
  logic [AW-1:0]      wb_addr_q, wb_addr_c;
  logic [WIDTH-1:0]   wb_data_q, wb_data_c;
  logic               in_wb, calc_last, use_fix;
  logic [WIDTH-1:0]   a_in, b_in;

`ifdef MULDIV_SIGNED_EN
  logic sgn_q, neg_a, neg_b;
  assign a_in    = (bus.sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_in    = (bus.sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  assign use_fix = sgn_q;
`else
  assign a_in    = bus.a;
  assign b_in    = bus.b;
  assign use_fix = 1'b0;
`endif

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each cycle.
  // Divide: acc[WIDTH-1:0] shifts dividend bits out of the MSB and quotient bits in at the LSB.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_diff;
  logic             div_ok;

  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opa} : '0);
  assign div_shift = {rem[WIDTH-1:0], acc[WIDTH-1]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, opb};
  assign div_ok    = ~div_diff[WIDTH+1];
  assign calc_last = (cnt == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (bus.start) state_nx = S_CALC;
      S_CALC: begin
        if (calc_last) begin
`ifdef MULDIV_SIGNED_EN
          state_nx = use_fix ? S_FIX : S_WB_LO;
`else
          state_nx = S_WB_LO;
`endif
        end
      end
`ifdef MULDIV_SIGNED_EN
      S_FIX:   state_nx = S_WB_LO;
`endif
      S_WB_LO: state_nx = (op_q == OP_MULW) ? S_WB_HI : S_IDLE;
      S_WB_HI: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_wb     = (state == S_WB_LO) || (state == S_WB_HI);
    wb_addr_c = wb_addr_q;
    wb_data_c = wb_data_q;
    if (state == S_WB_LO) begin
      wb_addr_c = rd_q;
      wb_data_c = (op_q == OP_MOD) ? rem[WIDTH-1:0] : acc[WIDTH-1:0];
    end else if (state == S_WB_HI) begin
      wb_addr_c = rd_q + 1'b1;
      wb_data_c = acc[2*WIDTH-1:WIDTH];
    end
    bus.busy     = (state != S_IDLE);
    bus.stall    = (state != S_IDLE) || (bus.start && (state == S_IDLE));
    bus.wb_addr  = wb_addr_c;
    bus.wb_data  = wb_data_c;
    // Register 0 is hard-wired, so a write aimed at it is dropped but still completes the op.
    bus.wb_we    = in_wb && (wb_addr_c != '0);
    bus.done     = ((state == S_WB_LO) && (op_q != OP_MULW)) || (state == S_WB_HI);
    bus.div_zero = div_zero_q;
    state_dbg    = state;
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q       <= '0;
      rd_q       <= '0;
      opa        <= '0;
      opb        <= '0;
      acc        <= '0;
      rem        <= '0;
      cnt        <= '0;
      div_zero_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
`ifdef MULDIV_SIGNED_EN
      sgn_q      <= 1'b0;
      neg_a      <= 1'b0;
      neg_b      <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            op_q       <= bus.op;
            rd_q       <= bus.rd;
            opa        <= a_in;
            opb        <= b_in;
            acc        <= {{WIDTH{1'b0}}, (bus.op[1] ? a_in : b_in)};
            rem        <= '0;
            cnt        <= '0;
            div_zero_q <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            sgn_q      <= bus.sgn;
            neg_a      <= bus.sgn && bus.a[WIDTH-1];
            neg_b      <= bus.sgn && bus.b[WIDTH-1];
`endif
          end
        end
        S_CALC: begin
          cnt <= cnt + 1'b1;
          if (!op_q[1]) begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end else begin
            rem              <= div_ok ? div_diff[WIDTH:0] : div_shift;
            acc[WIDTH-1:0]   <= {acc[WIDTH-2:0], div_ok};
          end
          if (calc_last && op_q[1] && (opb == '0)) div_zero_q <= 1'b1;
        end
`ifdef MULDIV_SIGNED_EN
        S_FIX: begin
          if (!op_q[1]) begin
            if (neg_a ^ neg_b) acc <= -acc;
          end else begin
            // A zero divisor keeps the all-ones quotient regardless of the dividend sign.
            if ((neg_a ^ neg_b) && (opb != '0)) acc[WIDTH-1:0] <= -acc[WIDTH-1:0];
            if (neg_a) rem[WIDTH-1:0] <= -rem[WIDTH-1:0];
          end
        end
`endif
        S_WB_LO, S_WB_HI: begin
          wb_addr_q <= wb_addr_c;
          wb_data_q <= wb_data_c;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed cases plus random ops against an arithmetic reference model.
// Builds with or without MULDIV_SIGNED_EN.
module tb_muldiv_seq;
  localparam int W  = 8;
  localparam int AW = 4;

  // Clock/reset
  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] state_dbg;
  always #5 clk = ~clk;

  muldiv_seq_if #(.WIDTH(W), .AW(AW)) bus ();

  muldiv_seq #(.WIDTH(W), .AW(AW), .CW(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // Scoreboard
  int           checks = 0;
  int           errors = 0;
  int           we_count = 0;
  logic [W-1:0] exp_q[$];

  always @(negedge clk) if (bus.wb_we === 1'b1) we_count++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic
  function automatic void model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input bit sg, output logic [W-1:0] lo, output logic [W-1:0] hi);
    int ia, ib, p, q, r;
    if (sg) begin
      ia = int'($signed(a));
      ib = int'($signed(b));
    end else begin
      ia = int'(a);
      ib = int'(b);
    end
    p = ia * ib;
    if (b == '0) begin
      q = 255;
      r = ia;
    end else begin
      q = ia / ib;
      r = ia % ib;
    end
    case (op)
      2'd2:    lo = q[W-1:0];
      2'd3:    lo = r[W-1:0];
      default: lo = p[W-1:0];
    endcase
    hi = p[2*W-1:W];
  endfunction

  // Drivers
  task automatic drive_req(input bit st, input logic [1:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [AW-1:0] rd, input bit sg);
    bus.start = st;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.rd    = rd;
`ifdef MULDIV_SIGNED_EN
    bus.sgn   = sg;
`else
    if (sg) $display("note: sgn ignored in unsigned build");
`endif
  endtask

  task automatic junk_req(input bit st);
    drive_req(st, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 4'($urandom), 1'b0);
  endtask

  task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [AW-1:0] rd, input bit sg, input bit noise, input bit late_start);
    logic [W-1:0]  lo, hi, last;
    logic [AW-1:0] addr;
    int            lat;
    model(op, a, b, sg, lo, hi);
    exp_q.push_back(lo);
    if (op == 2'b01) exp_q.push_back(hi);
    lat = sg ? W + 1 : W;

    @(negedge clk);
    drive_req(1'b1, op, a, b, rd, sg);
    #1 chk("stall_on_start", bus.stall, 1);
    @(negedge clk);
    junk_req(1'b0);
    chk("busy_after_start", bus.busy, 1);
    chk("div_zero_cleared", bus.div_zero, 0);
    for (int i = 1; i < lat; i++) begin
      @(negedge clk);
      junk_req(noise && (i == 3));
      chk("no_early_wb", bus.wb_we, 0);
    end

    @(negedge clk);
    bus.start = late_start && (op != 2'b01);
    last = exp_q.pop_front();
    addr = rd;
    chk("wb_lo_addr", bus.wb_addr, addr);
    chk("wb_lo_data", bus.wb_data, last);
    chk("wb_lo_we", bus.wb_we, (addr != 0));
    chk("wb_lo_done", bus.done, (op != 2'b01));
    if (op == 2'b01) begin
      @(negedge clk);
      bus.start = late_start;
      last = exp_q.pop_front();
      addr = rd + 1'b1;
      chk("wb_hi_addr", bus.wb_addr, addr);
      chk("wb_hi_data", bus.wb_data, last);
      chk("wb_hi_we", bus.wb_we, (addr != 0));
      chk("wb_hi_done", bus.done, 1);
    end

    @(negedge clk);
    bus.start = 1'b0;
    chk("idle_busy", bus.busy, 0);
    chk("idle_done", bus.done, 0);
    chk("idle_we", bus.wb_we, 0);
    chk("hold_addr", bus.wb_addr, addr);
    chk("hold_data", bus.wb_data, last);
    chk("div_zero", bus.div_zero, (op[1] && (b == 0)));
    @(negedge clk);
    chk("late_start_ignored", bus.busy, 0);
  endtask

  // Stimulus
  initial begin
    int w0;
    logic [1:0] rop;
    logic [W-1:0] ra, rb;
    reset = 1'b1;
    drive_req(1'b0, 2'b00, '0, '0, '0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_stall", bus.stall, 0);
    chk("rst_we", bus.wb_we, 0);
    chk("rst_addr", bus.wb_addr, 0);
    chk("rst_data", bus.wb_data, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_div_zero", bus.div_zero, 0);
    chk("rst_state", state_dbg, 0);
    reset = 1'b0;

    do_op(2'b00, 8'd13, 8'd11, 4'd3, 1'b0, 1'b0, 1'b0);
    do_op(2'b01, 8'hFF, 8'hFF, 4'd15, 1'b0, 1'b0, 1'b0);
    do_op(2'b10, 8'd200, 8'd7, 4'd5, 1'b0, 1'b0, 1'b0);
    do_op(2'b11, 8'd200, 8'd7, 4'd6, 1'b0, 1'b0, 1'b0);
    do_op(2'b10, 8'd50, 8'd0, 4'd7, 1'b0, 1'b0, 1'b0);
    do_op(2'b00, 8'd2, 8'd3, 4'd8, 1'b0, 1'b0, 1'b0);
    do_op(2'b11, 8'd77, 8'd0, 4'd1, 1'b0, 1'b1, 1'b1);
    do_op(2'b00, 8'd9, 8'd9, 4'd0, 1'b0, 1'b1, 1'b1);
    do_op(2'b01, 8'd200, 8'd100, 4'd4, 1'b0, 1'b0, 1'b1);
`ifdef MULDIV_SIGNED_EN
    do_op(2'b01, 8'hFA, 8'd7, 4'd2, 1'b1, 1'b0, 1'b0);
    do_op(2'b10, 8'hF9, 8'd2, 4'd3, 1'b1, 1'b0, 1'b0);
    do_op(2'b11, 8'hF9, 8'd2, 4'd3, 1'b1, 1'b0, 1'b0);
    do_op(2'b10, 8'h80, 8'hFF, 4'd9, 1'b1, 1'b0, 1'b0);
    do_op(2'b10, 8'hF9, 8'd0, 4'd9, 1'b1, 1'b0, 1'b0);
    do_op(2'b11, 8'hF9, 8'd0, 4'd9, 1'b1, 1'b0, 1'b0);
`endif

    for (int n = 0; n < 30; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = 8'($urandom);
      rb  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
`ifdef MULDIV_SIGNED_EN
      do_op(rop, ra, rb, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
`else
      do_op(rop, ra, rb, 4'($urandom_range(0, 15)), 1'b0,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
`endif
    end

    // Abort: second start in cycle 4 is ignored, reset in cycle 6 kills the op
    @(negedge clk);
    drive_req(1'b1, 2'b00, 8'd9, 8'd5, 4'd2, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    drive_req(1'b1, 2'b01, 8'd1, 8'd1, 4'd4, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    chk("second_start_busy", bus.busy, 1);
    @(negedge clk);
    w0 = we_count;
    reset = 1'b1;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_stall", bus.stall, 0);
    chk("abort_we", bus.wb_we, 0);
    chk("abort_addr", bus.wb_addr, 0);
    chk("abort_data", bus.wb_data, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_state", state_dbg, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (14) @(negedge clk);
    chk("abort_no_wb", we_count - w0, 0);
    chk("abort_stays_idle", bus.busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
